// File: rtl/div8x4_if.sv
// rtl/div8x4_if.sv - start/done handshake and operand/result bundle for the 8/4 divider
interface div8x4_if #(
  parameter int DW = 8,
  parameter int VW = 4
);
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          done_flag;
  logic          busy;
  logic          div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, done_flag, busy, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, done_flag, busy, div_by_zero
  );
endinterface

// File: rtl/div8x4.sv
// rtl/div8x4.sv - sequential restoring divider, one quotient bit per clock
module div8x4 #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  div8x4_if.slave bus
);
  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dreg;
  logic [VW-1:0] dvs;
  logic [VW:0]   prem;
  logic [DW-1:0] qsr;

  logic [DW-1:0] q_reg;
  logic [VW-1:0] r_reg;
  logic          done_reg;
  logic          busy_reg;
  logic          dbz_reg;

  logic [VW:0]   t;
  logic          ge;
  logic [VW:0]   prem_nx;
  logic [DW-1:0] q_nx;

  // One restoring step: the extra prem bit keeps the compare from overflowing.
  always_comb begin
    t       = {prem[VW-1:0], dreg[DW-1]};
    ge      = (t >= {1'b0, dvs});
    prem_nx = ge ? (t - {1'b0, dvs}) : t;
    q_nx    = {qsr[DW-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      dreg     <= '0;
      dvs      <= '0;
      prem     <= '0;
      qsr      <= '0;
      q_reg    <= '0;
      r_reg    <= '0;
      done_reg <= 1'b0;
      busy_reg <= 1'b0;
      dbz_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            dreg <= bus.dividend;
            dvs  <= bus.divisor;
            cnt  <= '0;
            prem <= '0;
            qsr  <= '0;
            if (bus.divisor == '0) begin
              q_reg    <= '1;
              r_reg    <= '0;
              dbz_reg  <= 1'b1;
              done_reg <= 1'b1;
              state    <= DONE;
            end else begin
              done_reg <= 1'b0;
              dbz_reg  <= 1'b0;
              busy_reg <= 1'b1;
              state    <= CALC;
            end
          end
        end
        CALC: begin
          dreg <= dreg << 1;
          prem <= prem_nx;
          qsr  <= q_nx;
          cnt  <= cnt + 1'b1;
          // Final step writes the results straight from the next-state values.
          if (cnt == LAST) begin
            q_reg    <= q_nx;
            r_reg    <= prem_nx[VW-1:0];
            done_reg <= 1'b1;
            busy_reg <= 1'b0;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.quotient    = q_reg;
  assign bus.remainder   = r_reg;
  assign bus.done_flag   = done_reg;
  assign bus.busy        = busy_reg;
  assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_div8x4.sv
// tb/tb_div8x4.sv - directed vector and back-to-back sweep bench for div8x4
module tb_div8x4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  div8x4_if #(.DW(8), .VW(4)) bus ();

  div8x4 #(.DW(8), .VW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
  } vec_t;

  vec_t vt [14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_result(input string name, input logic [7:0] q, input logic [3:0] r,
                            input logic z);
    chk({name, " quotient"}, int'(bus.quotient), int'(q));
    chk({name, " remainder"}, int'(bus.remainder), int'(r));
    chk({name, " div_by_zero"}, int'(bus.div_by_zero), int'(z));
    chk({name, " done_flag"}, int'(bus.done_flag), 1);
    chk({name, " busy"}, int'(bus.busy), 0);
  endtask

  // One start pulse; returns edges counted from the start edge to done_flag and busy cycles.
  task automatic do_op(input logic [7:0] a, input logic [3:0] b, output int edges,
                       output int busy_cnt);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    edges     = 1;
    busy_cnt  = bus.busy ? 1 : 0;
    chk("done after start edge", int'(bus.done_flag), (b == 0) ? 1 : 0);
    while (!bus.done_flag && edges < 20) begin
      tick();
      edges++;
      if (bus.busy) busy_cnt++;
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, " quotient"}, int'(bus.quotient), 0);
    chk({name, " remainder"}, int'(bus.remainder), 0);
    chk({name, " done_flag"}, int'(bus.done_flag), 0);
    chk({name, " busy"}, int'(bus.busy), 0);
    chk({name, " div_by_zero"}, int'(bus.div_by_zero), 0);
  endtask

  initial begin
    int edges;
    int busy_cnt;
    int k;
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] eq;
    logic [3:0] er;

    vt[0]  = '{8'd200, 4'd7,  8'd28,  4'd4,  1'b0};
    vt[1]  = '{8'd255, 4'd1,  8'd255, 4'd0,  1'b0};
    vt[2]  = '{8'd9,   4'd15, 8'd0,   4'd9,  1'b0};
    vt[3]  = '{8'd100, 4'd0,  8'hFF,  4'd0,  1'b1};
    vt[4]  = '{8'd240, 4'd15, 8'd16,  4'd0,  1'b0};
    vt[5]  = '{8'd0,   4'd5,  8'd0,   4'd0,  1'b0};
    vt[6]  = '{8'd255, 4'd15, 8'd17,  4'd0,  1'b0};
    vt[7]  = '{8'd254, 4'd15, 8'd16,  4'd14, 1'b0};
    vt[8]  = '{8'd127, 4'd2,  8'd63,  4'd1,  1'b0};
    vt[9]  = '{8'd17,  4'd4,  8'd4,   4'd1,  1'b0};
    vt[10] = '{8'd1,   4'd0,  8'hFF,  4'd0,  1'b1};
    vt[11] = '{8'd15,  4'd15, 8'd1,   4'd0,  1'b0};
    vt[12] = '{8'd8,   4'd9,  8'd0,   4'd8,  1'b0};
    vt[13] = '{8'd255, 4'd8,  8'd31,  4'd7,  1'b0};

    bus.start    = 1'b0;
    bus.dividend = 8'd0;
    bus.divisor  = 4'd0;
    rst_n        = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();
    chk_all_zero("idle");

    foreach (vt[i]) begin
      do_op(vt[i].a, vt[i].b, edges, busy_cnt);
      chk($sformatf("vec%0d latency", i), edges, (vt[i].b == 0) ? 1 : 9);
      chk($sformatf("vec%0d busy cycles", i), busy_cnt, (vt[i].b == 0) ? 0 : 8);
      chk_result($sformatf("vec%0d", i), vt[i].q, vt[i].r, vt[i].z);
      tick();
      chk($sformatf("vec%0d held quotient", i), int'(bus.quotient), int'(vt[i].q));
      chk($sformatf("vec%0d held done", i), int'(bus.done_flag), 1);
    end

    // Start pulse during CALC must be ignored.
    bus.dividend = 8'd200;
    bus.divisor  = 4'd7;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.dividend = 8'd15;
    bus.divisor  = 4'd3;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    edges = 4;
    while (!bus.done_flag && edges < 20) begin
      tick();
      edges++;
    end
    chk("ignored start latency", edges, 9);
    chk_result("ignored start", 8'd28, 4'd4, 1'b0);

    // Reset mid-CALC, then restart.
    bus.dividend = 8'd240;
    bus.divisor  = 4'd15;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    chk("busy before reset", int'(bus.busy), 1);
    rst_n = 1'b0;
    tick();
    chk_all_zero("mid reset");
    rst_n = 1'b1;
    tick();
    chk_all_zero("after reset idle");
    do_op(8'd240, 4'd15, edges, busy_cnt);
    chk("restart latency", edges, 9);
    chk_result("restart", 8'd16, 4'd0, 1'b0);

    // Back-to-back sweep of all pairs in a scrambled order with start held high.
    k = 59;
    bus.dividend = k[11:4];
    bus.divisor  = k[3:0];
    bus.start    = 1'b1;
    tick();
    edges = 1;
    for (int i = 0; i < 4096; i++) begin
      k = (i * 1237 + 59) % 4096;
      a = k[11:4];
      b = k[3:0];
      while (!bus.done_flag && edges < 20) begin
        tick();
        edges++;
      end
      if (b == 0) begin
        eq = 8'hFF;
        er = 4'd0;
      end else begin
        eq = a / b;
        er = a % b;
      end
      chk($sformatf("sweep %0d/%0d period", a, b), edges, (b == 0) ? 1 : 9);
      chk_result($sformatf("sweep %0d/%0d", a, b), eq, er, (b == 0));
      if (i < 4095) begin
        k = ((i + 1) * 1237 + 59) % 4096;
        bus.dividend = k[11:4];
        bus.divisor  = k[3:0];
        tick();
        edges = 1;
      end
    end
    bus.start = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
